// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; the master modport is the traffic/memory side.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_wr_rd;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_wr_rd;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              mem_en;
  logic              mem_wr_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  req0_valid, req0_wr_rd, req0_addr, req0_wdata,
    input  req1_valid, req1_wr_rd, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mem_en, mem_wr_rd, mem_addr, mem_data_in,
    input  mem_data_out,
    output busy
  );

  modport master (
    output req0_valid, req0_wr_rd, req0_addr, req0_wdata,
    output req1_valid, req1_wr_rd, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mem_en, mem_wr_rd, mem_addr, mem_data_in,
    output mem_data_out,
    input  busy
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter sequencing one access at a time into a single-port memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise req0 has fixed priority.
module mem_access_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              id_q;
  logic              mem_en_q;
  logic              mem_wr_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_rdata_q;
  logic [DATA_W-1:0] rsp1_rdata_q;
  logic              busy_q;

  logic              any_valid;
  logic              gnt1;
  logic              sel_wr_rd_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef MEM_ARB_RR_EN
  // last_grant_q=1 means req1 won last, so a tie goes to req0.
  logic last_grant_q;
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
`else
  assign gnt1 = bus.req1_valid & ~bus.req0_valid;
`endif

  assign sel_wr_rd_d = gnt1 ? bus.req1_wr_rd : bus.req0_wr_rd;
  assign sel_addr_d  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata_d = gnt1 ? bus.req1_wdata : bus.req0_wdata;

  // Ready is gated by rst so every output is 0 while reset is held.
  assign bus.req0_ready = rst & (state_q == IDLE) & bus.req0_valid & ~gnt1;
  assign bus.req1_ready = rst & (state_q == IDLE) & gnt1;

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr_rd   = mem_wr_rd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_rdata  = rsp0_rdata_q;
  assign bus.rsp1_rdata  = rsp1_rdata_q;
  assign bus.busy        = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_wr_rd_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_rdata_q  <= '0;
      rsp1_rdata_q  <= '0;
      busy_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      mem_en_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            // The mem_* registers double as the command latch and hold after ISSUE.
            state_q       <= ISSUE;
            id_q          <= gnt1;
            mem_en_q      <= 1'b1;
            mem_wr_rd_q   <= sel_wr_rd_d;
            mem_addr_q    <= sel_addr_d;
            mem_data_in_q <= sel_wdata_d;
            busy_q        <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_grant_q  <= gnt1;
`endif
          end
        end
        ISSUE: begin
          if (mem_wr_rd_q) begin
            state_q      <= DONE;
            rsp0_valid_q <= ~id_q;
            rsp1_valid_q <= id_q;
          end else begin
            state_q <= WAIT;
            cnt_q   <= 3'd1;
          end
        end
        WAIT: begin
          if (cnt_q == LAT_LAST) begin
            state_q      <= DONE;
            rsp0_valid_q <= ~id_q;
            rsp1_valid_q <= id_q;
            if (id_q) rsp1_rdata_q <= bus.mem_data_out;
            else      rsp0_rdata_q <= bus.mem_data_out;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed table, tie/reset sequences and random traffic
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_access_arbiter;

  localparam int RD_LAT = 3;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks;
  int   failures;

  mem_access_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  mem_access_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: synchronous writes, reads delivered RD_LAT cycles after mem_en.
  logic [7:0] dmem [64] = '{default: 8'h00};
  logic [7:0] dly  [RD_LAT];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr_rd) dmem[bus.mem_addr] <= bus.mem_data_in;
    dly[0] <= (bus.mem_en && !bus.mem_wr_rd) ? dmem[bus.mem_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end
  assign bus.mem_data_out = dly[RD_LAT-1];

  // Transaction-level model state (one outstanding command at most).
  logic [7:0] mmem [64] = '{default: 8'h00};
  bit         m_have = 1'b0;
  bit         m_lg   = 1'b1;
  bit         m_id;
  bit         m_wr;
  logic [5:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  int         m_acc;
  int         m_rsp;

  typedef struct {
    logic       id;
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {27'b0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
            bus.rsp0_rdata, bus.rsp1_rdata, bus.mem_en, bus.mem_wr_rd,
            bus.mem_addr, bus.mem_data_in, bus.busy};
  endfunction

  task automatic set_req(input logic id, input logic v, input logic wr,
                         input logic [5:0] a, input logic [7:0] d);
    if (id) begin
      bus.req1_valid = v; bus.req1_wr_rd = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = v; bus.req0_wr_rd = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  task automatic monitor();
    bit         win;
    bit         idle;
    logic [1:0] exp_r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_have = 1'b0;
        m_lg   = 1'b1;
        chk("reset_outputs", outs_vec(), 64'd0);
      end else begin
        idle = !(m_have && cyc <= m_rsp);
`ifdef MEM_ARB_RR_EN
        win = (bus.req0_valid && bus.req1_valid) ? !m_lg : bus.req1_valid;
`else
        win = !bus.req0_valid;
`endif
        exp_r = (idle && (bus.req0_valid || bus.req1_valid)) ? (win ? 2'b10 : 2'b01) : 2'b00;
        chk("ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(exp_r));
        chk("busy", 64'(bus.busy), 64'(m_have && cyc > m_acc && cyc <= m_rsp));
        chk("mem_en", 64'(bus.mem_en), 64'(m_have && cyc == m_acc + 1));
        if (m_have && cyc == m_acc + 1)
          chk("mem_cmd", 64'({bus.mem_wr_rd, bus.mem_addr, bus.mem_data_in}),
              64'({m_wr, m_addr, m_wdata}));
        if (m_have && cyc == m_rsp) begin
          chk("rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), m_id ? 64'd2 : 64'd1);
          chk("rsp_rdata", 64'(m_id ? bus.rsp1_rdata : bus.rsp0_rdata),
              64'(m_wr ? 8'h00 : m_rdata));
        end else begin
          chk("rsp_quiet", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        end
        if (exp_r != 2'b00) begin
          m_have  = 1'b1;
          m_id    = win;
          m_lg    = win;
          m_acc   = cyc;
          m_wr    = win ? bus.req1_wr_rd : bus.req0_wr_rd;
          m_addr  = win ? bus.req1_addr  : bus.req0_addr;
          m_wdata = win ? bus.req1_wdata : bus.req0_wdata;
          m_rsp   = cyc + (m_wr ? 2 : 2 + RD_LAT);
          if (m_wr) mmem[m_addr] = m_wdata;
          else      m_rdata = mmem[m_addr];
        end
      end
    end
  endtask

  task automatic do_cmd(input logic id, input logic wr, input logic [5:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat, output int en_lat,
                        output logic [5:0] ea);
    int t0;
    bit got;
    rd = 8'h00; lat = -1; en_lat = -1; ea = 6'h00; t0 = 0;
    @(posedge clk); #1;
    set_req(id, 1'b1, wr, a, d);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin got = 1'b1; t0 = cyc; end
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, wr, a, d);
    if (!got) begin chk("accept_timeout", 64'd0, 64'd1); return; end
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_en && en_lat < 0) begin en_lat = cyc - t0; ea = bus.mem_addr; end
      if (id ? bus.rsp1_valid : bus.rsp0_valid) begin
        got = 1'b1; lat = cyc - t0; rd = id ? bus.rsp1_rdata : bus.rsp0_rdata;
      end
    end
    if (!got) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic tie_run(input int n, input string nm);
    int   g[$];
    logic r0, r1;
    int   exp;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 6'($urandom_range(0, 63)), 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 6'($urandom_range(0, 63)), 8'h00);
    for (int k = 0; k < 300 && (bus.req0_valid || bus.req1_valid); k++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      if (r0 || r1) g.push_back(r1 ? 1 : 0);
      @(posedge clk); #1;
      if (r0) set_req(1'b0, 1'(g.size() < n), 1'b0, 6'($urandom_range(0, 63)), 8'h00);
      if (r1) set_req(1'b1, 1'(g.size() < n), 1'b0, 6'($urandom_range(0, 63)), 8'h00);
    end
    if (bus.req0_valid || bus.req1_valid) begin
      chk("tie_timeout", 64'd0, 64'd1);
      set_req(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    end
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
      exp = i % 2;
`else
      exp = 0;
`endif
      if (i < g.size()) chk(nm, 64'(g[i]), 64'(exp));
      else              chk({nm, "_missing"}, 64'd1, 64'd0);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         lat, en_lat;
    logic [5:0] ea;
    logic       r0, r1;
    bit         got, saw;

    checks = 0; failures = 0;
    set_req(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    rst = 1'b1;
    #1 rst = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs_vec(), 64'd0);
    rst = 1'b1;

    tbl[0] = '{id: 1'b0, wr: 1'b1, addr: 6'h05, wdata: 8'hA5, exp_rdata: 8'h00};
    tbl[1] = '{id: 1'b0, wr: 1'b0, addr: 6'h05, wdata: 8'h00, exp_rdata: 8'hA5};
    tbl[2] = '{id: 1'b1, wr: 1'b1, addr: 6'h3F, wdata: 8'h3C, exp_rdata: 8'h00};
    tbl[3] = '{id: 1'b1, wr: 1'b0, addr: 6'h3F, wdata: 8'h00, exp_rdata: 8'h3C};
    tbl[4] = '{id: 1'b0, wr: 1'b1, addr: 6'h00, wdata: 8'h5A, exp_rdata: 8'h00};
    tbl[5] = '{id: 1'b1, wr: 1'b0, addr: 6'h00, wdata: 8'h00, exp_rdata: 8'h5A};
    for (int i = 0; i < 6; i++) begin
      do_cmd(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, lat, en_lat, ea);
      chk("vec_rdata", 64'(rd), 64'(tbl[i].exp_rdata));
      chk("vec_rsp_latency", 64'(lat), 64'(tbl[i].wr ? 2 : 2 + RD_LAT));
      chk("vec_en_latency", 64'(en_lat), 64'd1);
      chk("vec_mem_addr", 64'(ea), 64'(tbl[i].addr));
    end

    tie_run(4, "tie_grant");

    // Abort a req0 read in WAIT; the following tie must go to req0 again.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 6'h05, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.req0_ready) got = 1'b1;
    end
    chk("rst_seq_accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 6'h05, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_seq_busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", outs_vec(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid || bus.mem_en) saw = 1'b1;
    end
    chk("rst_no_rsp", 64'(saw), 64'd0);
    tie_run(2, "post_reset_grant");

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (!bus.req0_valid || r0)
        set_req(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 6'h38 : 6'h00),
                8'($urandom_range(0, 255)));
      if (!bus.req1_valid || r1)
        set_req(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 6'h38 : 6'h00),
                8'($urandom_range(0, 255)));
    end
    for (int k = 0; k < 200 && (bus.req0_valid || bus.req1_valid); k++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (r0) set_req(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      if (r1) set_req(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    end
    chk("drain_valids", 64'({bus.req1_valid, bus.req0_valid}), 64'd0);
    repeat (12) @(negedge clk);
    chk("drain_idle", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
